// File: rtl/sat_pkg.sv
// Shared types and constants for the backtracking logic of the SAT solver core.
// Latency: n/a (types, constants and a saturating-increment helper only).
// Backpressure: n/a. Optional macro MAX_VARS_BITS sets the variable-index width (default 4).
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

package sat_pkg;

    localparam int VAR_BITS  = `MAX_VARS_BITS;
    localparam int NUM_VARS  = 2 ** VAR_BITS;
    localparam int STAT_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        READ,
        FLIP,
        DONE,
        UNSAT
    } bt_state_t;

    typedef logic [VAR_BITS-1:0] var_idx_t;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/decision_backtracker_flip_bitmap.sv
// One flag per variable: set when a decision has been flipped, cleared when it is unwound.
// Latency: combinational read, set/clear take effect on the next clock edge.
// Backpressure: none; set and clear are accepted every cycle.
// Ports: i_clock/i_reset (sync, active-high, clears every flag), i_rd_idx -> o_rd_flag,
//        i_set/i_set_idx, i_clr/i_clr_idx.
module flip_bitmap
    import sat_pkg::*;
(
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [VAR_BITS-1:0] i_rd_idx,
    output logic                o_rd_flag,
    input  logic                i_set,
    input  logic [VAR_BITS-1:0] i_set_idx,
    input  logic                i_clr,
    input  logic [VAR_BITS-1:0] i_clr_idx
);

    logic [NUM_VARS-1:0] r_flags;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_flags <= '0;
        end else begin
            if (i_clr) r_flags[i_clr_idx] <= 1'b0;
            if (i_set) r_flags[i_set_idx] <= 1'b1;
        end
    end

    assign o_rd_flag = r_flags[i_rd_idx];

endmodule

// File: rtl/decision_backtracker.sv
// Pops decisions on conflict, unwinds already-flipped ones, flips the first unflipped one and pushes it back.
// Latency: conflict at edge 0 -> pop cycle 1, write/push cycle 4, done cycle 5; +2 cycles per unwound entry.
// Backpressure: none; conflict is only sampled in IDLE, stack and variable table are assumed always ready.
// Ports: i_clock, i_reset (sync, active-high), i_conflict, i_stk_empty, i_stk_idx, o_stk_pop, o_stk_push,
//        o_stk_push_idx, o_va_rd_idx, i_va_rd_val, o_va_we, o_va_idx, o_va_val, o_va_unassign, o_busy, o_done,
//        o_unsat; o_bt_count/o_pop_count only when BACKTRACK_STATS_EN is defined.
module decision_backtracker
    import sat_pkg::*;
(
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_conflict,
    input  logic                 i_stk_empty,
    input  logic [VAR_BITS-1:0]  i_stk_idx,
    output logic                 o_stk_pop,
    output logic                 o_stk_push,
    output logic [VAR_BITS-1:0]  o_stk_push_idx,
    output logic [VAR_BITS-1:0]  o_va_rd_idx,
    input  logic                 i_va_rd_val,
    output logic                 o_va_we,
    output logic [VAR_BITS-1:0]  o_va_idx,
    output logic                 o_va_val,
    output logic                 o_va_unassign,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_unsat
`ifdef BACKTRACK_STATS_EN
    ,
    output logic [STAT_BITS-1:0] o_bt_count,
    output logic [STAT_BITS-1:0] o_pop_count
`endif
);

    bt_state_t           r_state;
    bt_state_t           w_next;
    logic [VAR_BITS-1:0] r_cur;
    logic                r_rd_val;
    logic                w_flag;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cur    <= '0;
            r_rd_val <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == WAIT) r_cur <= i_stk_idx;
            // Hold the table read data so FLIP does not depend on the read address staying put.
            if (r_state == READ) r_rd_val <= i_va_rd_val;
        end
    end

    flip_bitmap u_flip_bitmap (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_rd_idx  (i_stk_idx),
        .o_rd_flag (w_flag),
        .i_set     (r_state == FLIP),
        .i_set_idx (r_cur),
        .i_clr     ((r_state == WAIT) && w_flag),
        .i_clr_idx (i_stk_idx)
    );

    always_comb begin
        w_next         = r_state;
        o_stk_pop      = 1'b0;
        o_stk_push     = 1'b0;
        o_stk_push_idx = '0;
        o_va_rd_idx    = '0;
        o_va_we        = 1'b0;
        o_va_idx       = '0;
        o_va_val       = 1'b0;
        o_va_unassign  = 1'b0;
        o_done         = 1'b0;
        o_unsat        = 1'b0;
        o_busy         = (r_state != IDLE) && (r_state != UNSAT);
        case (r_state)
            IDLE: begin
                if (i_conflict) w_next = i_stk_empty ? UNSAT : POP;
            end
            POP: begin
                o_stk_pop = 1'b1;
                w_next    = WAIT;
            end
            WAIT: begin
                o_va_rd_idx = i_stk_idx;
                if (w_flag) begin
                    // Both polarities already tried: drop this decision and keep unwinding.
                    o_va_we       = 1'b1;
                    o_va_unassign = 1'b1;
                    o_va_idx      = i_stk_idx;
                    w_next        = i_stk_empty ? UNSAT : POP;
                end else begin
                    w_next = READ;
                end
            end
            READ: begin
                w_next = FLIP;
            end
            FLIP: begin
                o_va_we        = 1'b1;
                o_va_idx       = r_cur;
                o_va_val       = ~r_rd_val;
                o_stk_push     = 1'b1;
                o_stk_push_idx = r_cur;
                w_next         = DONE;
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            UNSAT: begin
                o_unsat = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef BACKTRACK_STATS_EN
    logic [STAT_BITS-1:0] r_bt_count;
    logic [STAT_BITS-1:0] r_pop_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bt_count  <= '0;
            r_pop_count <= '0;
        end else begin
            if (r_state == DONE) r_bt_count  <= sat_inc(r_bt_count);
            if (r_state == POP)  r_pop_count <= sat_inc(r_pop_count);
        end
    end

    assign o_bt_count  = r_bt_count;
    assign o_pop_count = r_pop_count;
`endif

endmodule

// File: tb/tb_decision_backtracker.sv
// Bench for decision_backtracker: behavioural stack/variable-table environment plus a reference model
// that predicts the outcome of each backtrack from the stack contents and a per-variable flipped set.
module tb_decision_backtracker;
    import sat_pkg::*;

    typedef logic [VAR_BITS-1:0] idx_t;

    logic clock = 1'b0;
    logic reset, conflict, stk_empty, va_rd_val;
    idx_t stk_idx, stk_push_idx, va_rd_idx, va_idx;
    logic stk_pop, stk_push, va_we, va_val, va_unassign, busy, done, unsat;
`ifdef BACKTRACK_STATS_EN
    logic [STAT_BITS-1:0] bt_count, pop_count;
`endif

    always #5 clock = ~clock;

    decision_backtracker dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_conflict     (conflict),
        .i_stk_empty    (stk_empty),
        .i_stk_idx      (stk_idx),
        .o_stk_pop      (stk_pop),
        .o_stk_push     (stk_push),
        .o_stk_push_idx (stk_push_idx),
        .o_va_rd_idx    (va_rd_idx),
        .i_va_rd_val    (va_rd_val),
        .o_va_we        (va_we),
        .o_va_idx       (va_idx),
        .o_va_val       (va_val),
        .o_va_unassign  (va_unassign),
        .o_busy         (busy),
        .o_done         (done),
        .o_unsat        (unsat)
`ifdef BACKTRACK_STATS_EN
        ,
        .o_bt_count     (bt_count),
        .o_pop_count    (pop_count)
`endif
    );

    // Environment state (the stack and the variable table as the DUT changes them).
    idx_t stack[$];
    logic vals[NUM_VARS];
    logic asg[NUM_VARS];
    // Reference model state.
    logic mflip[NUM_VARS];
    int   m_bt, m_pops;

    // Observations for the current backtrack.
    int cyc, o_pops, o_pushes, o_unassigns, o_flips, o_dones, overlap, underflow;
    int done_cyc, flip_cyc, unsat_cyc, first_pop_cyc;
    logic busy_at1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic clear_obs();
        cyc = 0; o_pops = 0; o_pushes = 0; o_unassigns = 0; o_flips = 0; o_dones = 0;
        overlap = 0; underflow = 0;
        done_cyc = -1; flip_cyc = -1; unsat_cyc = -1; first_pop_cyc = -1; busy_at1 = 1'b0;
    endtask

    // Called at a negedge: sample outputs, cross the posedge, then respond like a real stack/table.
    task automatic step();
        logic p, pu, we, un, vv;
        idx_t ri, wi, pi;
        p = stk_pop; pu = stk_push; we = va_we; un = va_unassign; vv = va_val;
        ri = va_rd_idx; wi = va_idx; pi = stk_push_idx;
        if (p) begin
            o_pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        if (p && pu) overlap++;
        if (pu) o_pushes++;
        if (we && un) o_unassigns++;
        if (we && !un) begin o_flips++; flip_cyc = cyc; end
        if (done) begin o_dones++; if (done_cyc < 0) done_cyc = cyc; end
        if (unsat && unsat_cyc < 0) unsat_cyc = cyc;
        if (cyc == 1) busy_at1 = busy;
        @(posedge clock);
        #1;
        if (p) begin
            if (stack.size() > 0) stk_idx = stack.pop_back();
            else underflow++;
        end
        va_rd_val = vals[ri];
        if (we) begin
            if (un) asg[wi] = 1'b0;
            else begin vals[wi] = vv; asg[wi] = 1'b1; end
        end
        if (pu) stack.push_back(pi);
        stk_empty = (stack.size() == 0);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; conflict = 1'b0;
        step(); step();
        reset = 1'b0;
        stack.delete();
        stk_empty = 1'b1;
        for (int v = 0; v < NUM_VARS; v++) mflip[v] = 1'b0;
        m_bt = 0; m_pops = 0;
    endtask

    // One conflict, predicted by the model and checked against what the environment observed.
    task automatic run_bt(input bit noise, input string name);
        idx_t es[$];
        logic ev[NUM_VARS];
        logic ea[NUM_VARS];
        int   k, epops, bad;
        bit   eu, empty0, fin;
        idx_t t;
        es = stack; ev = vals; ea = asg;
        k = 0; eu = 1'b0; fin = 1'b0;
        empty0 = (stack.size() == 0);
        if (empty0) eu = 1'b1;
        while (!eu && !fin) begin
            t = es.pop_back();
            if (mflip[t]) begin
                mflip[t] = 1'b0; ea[t] = 1'b0; k++;
                if (es.size() == 0) eu = 1'b1;
            end else begin
                ev[t] = ~ev[t]; ea[t] = 1'b1; es.push_back(t); mflip[t] = 1'b1; fin = 1'b1;
            end
        end
        epops = empty0 ? 0 : (eu ? k : k + 1);
        m_pops += epops;
        if (!eu) m_bt++;

        clear_obs();
        conflict = 1'b1;
        step();
        conflict = 1'b0;
        for (int i = 0; i < 60 && o_dones == 0 && unsat_cyc < 0; i++) begin
            if (noise) conflict = 1'($urandom_range(0, 1));
            step();
        end
        conflict = 1'b0;
        step(); step(); step();

        n_checks++;
        if (eu) begin
            if (unsat_cyc !== (empty0 ? 1 : 2 * k + 1)) begin
                n_errors++;
                $display("FAIL %s unsat_cycle: got %0d expected %0d", name, unsat_cyc, empty0 ? 1 : 2 * k + 1);
            end
        end else begin
            if (done_cyc !== 5 + 2 * k) begin
                n_errors++;
                $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, 5 + 2 * k);
            end
        end
        n_checks++;
        if (!eu && flip_cyc !== 4 + 2 * k) begin
            n_errors++;
            $display("FAIL %s flip_cycle: got %0d expected %0d", name, flip_cyc, 4 + 2 * k);
        end
        n_checks++;
        if (first_pop_cyc !== (epops > 0 ? 1 : -1)) begin
            n_errors++;
            $display("FAIL %s first_pop_cycle: got %0d expected %0d", name, first_pop_cyc, epops > 0 ? 1 : -1);
        end
        n_checks++;
        if (o_pops !== epops || underflow !== 0) begin
            n_errors++;
            $display("FAIL %s pops: got %0d (underflow %0d) expected %0d", name, o_pops, underflow, epops);
        end
        n_checks++;
        if (o_pushes !== (eu ? 0 : 1) || o_flips !== (eu ? 0 : 1) || o_dones !== (eu ? 0 : 1)) begin
            n_errors++;
            $display("FAIL %s push/flip/done counts: got %0d/%0d/%0d expected %0d each",
                     name, o_pushes, o_flips, o_dones, eu ? 0 : 1);
        end
        n_checks++;
        if (o_unassigns !== k) begin
            n_errors++;
            $display("FAIL %s unassigns: got %0d expected %0d", name, o_unassigns, k);
        end
        n_checks++;
        if (overlap !== 0) begin
            n_errors++;
            $display("FAIL %s pop_push_overlap: got %0d expected 0", name, overlap);
        end
        n_checks++;
        if (busy_at1 !== !(eu && empty0)) begin
            n_errors++;
            $display("FAIL %s busy_cycle1: got %0b expected %0b", name, busy_at1, !(eu && empty0));
        end
        n_checks++;
        if (unsat !== eu || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s final unsat/busy: got %0b/%0b expected %0b/0", name, unsat, busy, eu);
        end
        bad = (stack.size() != es.size()) ? 1 : 0;
        if (bad == 0)
            for (int i = 0; i < es.size(); i++) if (stack[i] !== es[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL %s stack: got size %0d expected size %0d (%0d differences)", name, stack.size(), es.size(), bad);
        end
        bad = 0;
        for (int v = 0; v < NUM_VARS; v++)
            if (asg[v] !== ea[v] || (ea[v] && vals[v] !== ev[v])) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL %s var_table: got %0d wrong entries expected 0", name, bad);
        end
`ifdef BACKTRACK_STATS_EN
        n_checks++;
        if (bt_count !== STAT_BITS'(m_bt) || pop_count !== STAT_BITS'(m_pops)) begin
            n_errors++;
            $display("FAIL %s stats: got bt %0d pop %0d expected bt %0d pop %0d", name, bt_count, pop_count, m_bt, m_pops);
        end
`endif
    endtask

    task automatic load(input idx_t v, input logic val);
        stack.push_back(v);
        vals[v] = val;
        asg[v] = 1'b1;
        stk_empty = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({stk_pop, stk_push, stk_push_idx, va_rd_idx, va_we, va_idx, va_val, va_unassign, busy, done, unsat} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {stk_pop, stk_push, stk_push_idx, va_rd_idx, va_we, va_idx, va_val, va_unassign, busy, done, unsat});
        end
`ifdef BACKTRACK_STATS_EN
        n_checks++;
        if (bt_count !== '0 || pop_count !== '0) begin
            n_errors++;
            $display("FAIL reset_stats: got %0d/%0d expected 0/0", bt_count, pop_count);
        end
`endif
    endtask

    task automatic test_single_then_unsat();
        do_reset();
        load(3, 1'b0);
        run_bt(1'b0, "single_flip");
        n_checks++;
        if (vals[3] !== 1'b1 || stack.size() != 1 || stack[0] !== idx_t'(3)) begin
            n_errors++;
            $display("FAIL single_flip var3: got %0b expected 1", vals[3]);
        end
        run_bt(1'b0, "unwind_unsat");
        n_checks++;
        if (unsat !== 1'b1 || asg[3] !== 1'b0) begin
            n_errors++;
            $display("FAIL unwind_unsat state: got unsat %0b assigned %0b expected 1/0", unsat, asg[3]);
        end
    endtask

    task automatic test_two_entries();
        do_reset();
        load(1, 1'b1);
        load(2, 1'b0);
        run_bt(1'b0, "flip_top2");
        run_bt(1'b0, "unwind2_flip1");
        n_checks++;
        if (vals[1] !== 1'b0 || asg[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL unwind2_flip1 table: got var1 %0b asg2 %0b expected 0/0", vals[1], asg[2]);
        end
    endtask

    task automatic test_empty();
        do_reset();
        run_bt(1'b0, "empty_stack");
    endtask

    task automatic test_reset_mid();
        do_reset();
        load(5, 1'b1);
        run_bt(1'b0, "pre_reset_flip");
        load(6, 1'b0);
        clear_obs();
        conflict = 1'b1;
        step();
        conflict = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({stk_pop, stk_push, stk_push_idx, va_rd_idx, va_we, va_idx, va_val, va_unassign, busy, done, unsat} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got %0h expected 0",
                     {stk_pop, stk_push, stk_push_idx, va_rd_idx, va_we, va_idx, va_val, va_unassign, busy, done, unsat});
        end
        step(); step();
        n_checks++;
        if (vals[6] !== 1'b0 || o_flips !== 0 || o_pushes !== 0) begin
            n_errors++;
            $display("FAIL reset_mid_partial_write: got var6 %0b flips %0d pushes %0d expected 0/0/0", vals[6], o_flips, o_pushes);
        end
        stack.delete();
        for (int v = 0; v < NUM_VARS; v++) mflip[v] = 1'b0;
        m_bt = 0; m_pops = 0;
        stk_empty = 1'b1;
        load(5, vals[5]);
        run_bt(1'b0, "post_reset_flip");
    endtask

    task automatic test_busy_conflict();
        do_reset();
        load(2, 1'($urandom_range(0, 1)));
        run_bt(1'b1, "busy_conflict");
    endtask

    task automatic test_random();
        int n;
        idx_t v;
        bit dup;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if (unsat) do_reset();
            n = $urandom_range(0, 3);
            for (int j = 0; j < n && stack.size() < NUM_VARS; j++) begin
                do begin
                    v = idx_t'($urandom_range(0, NUM_VARS - 1));
                    dup = 1'b0;
                    for (int s = 0; s < stack.size(); s++) if (stack[s] == v) dup = 1'b1;
                end while (dup);
                load(v, 1'($urandom_range(0, 1)));
            end
            run_bt(1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        reset = 1'b1; conflict = 1'b0; stk_empty = 1'b1; stk_idx = '0; va_rd_val = 1'b0;
        for (int v = 0; v < NUM_VARS; v++) begin vals[v] = 1'b0; asg[v] = 1'b0; mflip[v] = 1'b0; end
        m_bt = 0; m_pops = 0;
        clear_obs();
        @(negedge clock);
        test_reset();
        test_single_then_unsat();
        test_two_entries();
        test_empty();
        test_reset_mid();
        test_busy_conflict();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
